// File: rtl/cgra_multiport_ram_if.sv
// Port bundle for cgra_multiport_ram: per-port CGRA access bus, preload handshake and status.
// The master side drives accesses; the RAM sits on the slave side.
interface cgra_multiport_ram_if #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DEPTH     = 1024
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic                          enable;
  logic [NUM_PORTS*ADDR_W-1:0]   addr;
  logic [NUM_PORTS*DATA_W-1:0]   data_in;
  logic [NUM_PORTS-1:0]          w_rq;
  logic [NUM_PORTS*DATA_W-1:0]   data_out;
  logic                          load_valid;
  logic                          load_ready;
  logic [IDX_W-1:0]              load_addr;
  logic [DATA_W-1:0]             load_data;
  logic                          init_busy;
  logic                          err_oob;
  logic                          err_collision;
  logic [15:0]                   collision_count;

  modport master (
    output enable, addr, data_in, w_rq, load_valid, load_addr, load_data,
    input  data_out, load_ready, init_busy, err_oob, err_collision, collision_count
  );

  modport slave (
    input  enable, addr, data_in, w_rq, load_valid, load_addr, load_data,
    output data_out, load_ready, init_busy, err_oob, err_collision, collision_count
  );
endinterface

// File: rtl/cgra_multiport_ram.sv
// N-port shared CGRA scratchpad with read pipeline, collision/out-of-range flags and preload port.
// Define CGRA_MULTIPORT_RAM_CLEAR_EN to zero the array word-by-word after every reset.
module cgra_multiport_ram #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned BYTE_ADDR = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  cgra_multiport_ram_if.slave   bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [ADDR_W-1:0]    widx [NUM_PORTS];
  logic [NUM_PORTS-1:0] oob;
  logic [NUM_PORTS-1:0] wr_en;
  logic                 run;
  logic                 clearing;
  logic [IDX_W-1:0]     clr_idx;
  logic                 adv;
  logic                 any_oob;
  logic                 collision;
  logic                 load_fire;

  logic [DATA_W-1:0]    rd_pipe_q [READ_LAT][NUM_PORTS];
  logic                 err_oob_q;
  logic                 err_collision_q;
  logic [15:0]          collision_count_q;

`ifdef CGRA_MULTIPORT_RAM_CLEAR_EN
  typedef enum logic [0:0] {StClear, StRun} state_e;
  state_e           state_q;
  logic [IDX_W-1:0] clr_idx_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
    end else if (state_q == StClear) begin
      clr_idx_q <= clr_idx_q + 1'b1;
      if (clr_idx_q == IDX_W'(DEPTH - 1)) state_q <= StRun;
    end
  end

  assign run      = (state_q == StRun);
  assign clearing = (state_q == StClear);
  assign clr_idx  = clr_idx_q;
`else
  assign run      = 1'b1;
  assign clearing = 1'b0;
  assign clr_idx  = '0;
`endif

  assign bus.init_busy = clearing;
  assign adv           = bus.enable && run;
  // Gated by reset so the handshake reads 0 while reset is held.
  assign bus.load_ready = !reset && !bus.enable && run;
  assign load_fire      = bus.load_valid && bus.load_ready;

  always_comb begin
    any_oob   = 1'b0;
    collision = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      widx[k]  = (BYTE_ADDR != 0) ? (bus.addr[k*ADDR_W +: ADDR_W] >> 2)
                                  : bus.addr[k*ADDR_W +: ADDR_W];
      oob[k]   = (widx[k] >= ADDR_W'(DEPTH));
      wr_en[k] = adv && bus.w_rq[k] && !oob[k];
      if (adv && oob[k]) any_oob = 1'b1;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = i + 1; j < NUM_PORTS; j++) begin
        if (wr_en[i] && wr_en[j] && (widx[i] == widx[j])) collision = 1'b1;
      end
    end
  end

  // Array has no reset; later ports overwrite earlier ones so the highest port wins.
  always_ff @(posedge clock) begin
    if (clearing) begin
      mem[clr_idx] <= '0;
    end else if (load_fire) begin
      mem[bus.load_addr] <= bus.load_data;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (wr_en[k]) mem[widx[k][IDX_W-1:0]] <= bus.data_in[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < READ_LAT; s++) begin
        for (int k = 0; k < NUM_PORTS; k++) rd_pipe_q[s][k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        rd_pipe_q[0][k] <= oob[k] ? '0 : mem[widx[k][IDX_W-1:0]];
        for (int s = 1; s < READ_LAT; s++) rd_pipe_q[s][k] <= rd_pipe_q[s-1][k];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_oob_q         <= 1'b0;
      err_collision_q   <= 1'b0;
      collision_count_q <= '0;
    end else begin
      if (any_oob) err_oob_q <= 1'b1;
      if (collision) begin
        err_collision_q <= 1'b1;
        if (collision_count_q != 16'hFFFF) collision_count_q <= collision_count_q + 16'd1;
      end
    end
  end

  always_comb begin
    bus.data_out = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      bus.data_out[k*DATA_W +: DATA_W] = rd_pipe_q[READ_LAT-1][k];
    end
  end

  assign bus.err_oob         = err_oob_q;
  assign bus.err_collision   = err_collision_q;
  assign bus.collision_count = collision_count_q;
endmodule
